// File: rtl/lcd_ctrl.sv
// HD44780-style character LCD controller: power-up delay, init handshake, config bytes, char/clear.
// Optional macro LCD_CTRL_LINE_WRAP_EN inserts a DDRAM-address command when the cursor wraps.
module lcd_ctrl #(
   parameter logic [19:0] POWERUP_CYCLES = 20'd750000,
   parameter int unsigned COLS           = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       char_valid,
   input  logic [7:0] char_data,
   output logic       char_ready,
   input  logic       clear_req,
   input  logic       init_done,
   input  logic       send_data_done,
   output logic       do_init,
   output logic       do_send_data,
   output logic [7:0] data_to_send,
   output logic       lcdrs_in,
   output logic       busy,
   output logic [3:0] cursor_col,
   output logic       cursor_row
);

   typedef enum logic [3:0] {
      StPwrup, StInitPhy, StCfgSend, StCfgWait, StCfgRel, StReady, StTxSend, StTxWait, StTxRel
   } state_e;

   localparam logic [19:0] PwrupLast = POWERUP_CYCLES - 20'd1;
   localparam logic [3:0]  LastCol   = 4'(COLS - 1);
   localparam logic [7:0]  CmdClear  = 8'h01;

   state_e      state_q, state_d;
   logic [19:0] cnt_q, cnt_d;
   logic [1:0]  cfg_idx_q, cfg_idx_d;
   logic [7:0]  data_q, data_d;
   logic        rs_q, rs_d;
   logic [3:0]  col_q, col_d;
   logic        row_q, row_d;
   logic        clr_pend_q, clr_pend_d;
   logic        addr_pend_q, addr_pend_d;
   logic        clr_now;

   function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h28;
         2'd1:    return 8'h06;
         2'd2:    return 8'h0C;
         default: return 8'h01;
      endcase
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StPwrup;
         cnt_q       <= '0;
         cfg_idx_q   <= '0;
         data_q      <= '0;
         rs_q        <= 1'b0;
         col_q       <= '0;
         row_q       <= 1'b0;
         clr_pend_q  <= 1'b0;
         addr_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cfg_idx_q   <= cfg_idx_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         col_q       <= col_d;
         row_q       <= row_d;
         clr_pend_q  <= clr_pend_d;
         addr_pend_q <= addr_pend_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cfg_idx_d   = cfg_idx_q;
      data_d      = data_q;
      rs_d        = rs_q;
      col_d       = col_q;
      row_d       = row_q;
      addr_pend_d = addr_pend_q;
      // Clears arriving while busy are remembered; READY services them directly.
      clr_pend_d  = clr_pend_q | (clear_req & (state_q != StReady));
      clr_now     = clr_pend_q | clear_req;

      unique case (state_q)
         StPwrup: begin
            if (cnt_q == PwrupLast) state_d = StInitPhy;
            else                    cnt_d   = cnt_q + 20'd1;
         end
         StInitPhy: begin
            if (init_done) begin
               state_d   = StCfgSend;
               cfg_idx_d = 2'd0;
               data_d    = cfg_byte(2'd0);
               rs_d      = 1'b0;
            end
         end
         StCfgSend: state_d = StCfgWait;
         StCfgWait: if (send_data_done) state_d = StCfgRel;
         StCfgRel: begin
            if (!send_data_done) begin
               if (cfg_idx_q == 2'd3) begin
                  col_d = '0;
                  row_d = 1'b0;
                  if (clr_now) begin
                     state_d    = StTxSend;
                     data_d     = CmdClear;
                     rs_d       = 1'b0;
                     clr_pend_d = 1'b0;
                  end else begin
                     state_d = StReady;
                  end
               end else begin
                  cfg_idx_d = cfg_idx_q + 2'd1;
                  data_d    = cfg_byte(cfg_idx_q + 2'd1);
                  state_d   = StCfgSend;
               end
            end
         end
         StReady: begin
            if (clr_now) begin
               state_d    = StTxSend;
               data_d     = CmdClear;
               rs_d       = 1'b0;
               clr_pend_d = 1'b0;
            end else if (char_valid) begin
               state_d = StTxSend;
               data_d  = char_data;
               rs_d    = 1'b1;
            end
         end
         StTxSend: state_d = StTxWait;
         StTxWait: begin
            if (send_data_done) begin
               state_d = StTxRel;
               if (rs_q) begin
                  if (col_q == LastCol) begin
                     col_d = '0;
                     row_d = ~row_q;
`ifdef LCD_CTRL_LINE_WRAP_EN
                     addr_pend_d = 1'b1;
`endif
                  end else begin
                     col_d = col_q + 4'd1;
                  end
               end else if (data_q == CmdClear) begin
                  col_d = '0;
                  row_d = 1'b0;
               end
            end
         end
         StTxRel: begin
            if (!send_data_done) begin
               if (addr_pend_q) begin
                  // row_q already points at the row being entered.
                  addr_pend_d = 1'b0;
                  state_d     = StTxSend;
                  data_d      = row_q ? 8'hC0 : 8'h80;
                  rs_d        = 1'b0;
               end else if (clr_now) begin
                  state_d    = StTxSend;
                  data_d     = CmdClear;
                  rs_d       = 1'b0;
                  clr_pend_d = 1'b0;
               end else begin
                  state_d = StReady;
               end
            end
         end
         default: state_d = StPwrup;
      endcase
   end

   assign do_init      = (state_q == StInitPhy);
   assign do_send_data = (state_q == StCfgSend) | (state_q == StCfgWait) |
                         (state_q == StTxSend)  | (state_q == StTxWait);
   assign data_to_send = data_q;
   assign lcdrs_in     = rs_q;
   assign busy         = (state_q != StReady);
   assign char_ready   = (state_q == StReady) & ~clear_req & ~clr_pend_q;
   assign cursor_col   = col_q;
   assign cursor_row   = row_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: randomized character/clear traffic against a byte-stream model.
`timescale 1ns/1ps
module tb_lcd_ctrl;
   localparam int unsigned COLS     = 16;
   localparam int          INIT_LAT = 50;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       char_valid = 1'b0;
   logic       clear_req = 1'b0;
   logic [7:0] char_data = 8'h00;
   logic       init_done, send_data_done;
   logic       char_ready, do_init, do_send_data, lcdrs_in, busy, cursor_row;
   logic [7:0] data_to_send;
   logic [3:0] cursor_col;

   int checks = 0;
   int failures = 0;

   // Bytes seen by the physical layer and bytes the model expects, as {rs, data}.
   logic [8:0] sent_q[$];
   logic [8:0] exp_q[$];
   int         mcol = 0;
   logic       mrow = 1'b0;

   int         init_cnt, byte_cnt, byte_lat, rel_cnt, rel_lat;
   logic [8:0] held;

   always #5 clk = ~clk;

   lcd_ctrl #(.POWERUP_CYCLES(20'd10), .COLS(COLS)) dut (
      .clk           (clk),
      .reset         (reset),
      .char_valid    (char_valid),
      .char_data     (char_data),
      .char_ready    (char_ready),
      .clear_req     (clear_req),
      .init_done     (init_done),
      .send_data_done(send_data_done),
      .do_init       (do_init),
      .do_send_data  (do_send_data),
      .data_to_send  (data_to_send),
      .lcdrs_in      (lcdrs_in),
      .busy          (busy),
      .cursor_col    (cursor_col),
      .cursor_row    (cursor_row)
   );

   // Physical-layer model: init after INIT_LAT cycles, random byte and release latencies.
   initial begin
      init_done = 1'b0;
      send_data_done = 1'b0;
      init_cnt = 0; byte_cnt = 0; byte_lat = 1; rel_cnt = 0; rel_lat = 0; held = '0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            init_done = 1'b0; send_data_done = 1'b0;
            init_cnt = 0; byte_cnt = 0; rel_cnt = 0;
         end else begin
            if (do_init && !init_done) begin
               init_cnt++;
               if (init_cnt >= INIT_LAT) init_done = 1'b1;
            end
            if (do_send_data && !send_data_done) begin
               if (byte_cnt == 0) begin
                  held = {lcdrs_in, data_to_send};
                  byte_lat = $urandom_range(4, 1);
               end else begin
                  checks++;
                  if ({lcdrs_in, data_to_send} !== held) begin
                     failures++;
                     $display("FAIL hold_stable: got %h required %h", {lcdrs_in, data_to_send}, held);
                  end
               end
               byte_cnt++;
               if (byte_cnt >= byte_lat) begin
                  send_data_done = 1'b1;
                  sent_q.push_back(held);
                  byte_cnt = 0; rel_cnt = 0;
                  rel_lat = $urandom_range(2, 0);
               end
            end else if (!do_send_data && send_data_done) begin
               if (rel_cnt >= rel_lat) send_data_done = 1'b0;
               else rel_cnt++;
            end
         end
      end
   end

   function automatic void model_char(input logic [7:0] c);
      exp_q.push_back({1'b1, c});
      mcol++;
      if (mcol == COLS) begin
         mcol = 0;
         mrow = ~mrow;
`ifdef LCD_CTRL_LINE_WRAP_EN
         exp_q.push_back({1'b0, (mrow ? 8'hC0 : 8'h80)});
`endif
      end
   endfunction

   function automatic void model_clear();
      exp_q.push_back({1'b0, 8'h01});
      mcol = 0;
      mrow = 1'b0;
   endfunction

   // Index of first disagreement between the observed and expected streams, -1 if identical.
   function automatic int first_diff();
      int m = (sent_q.size() > exp_q.size()) ? sent_q.size() : exp_q.size();
      for (int i = 0; i < m; i++) begin
         if (i >= sent_q.size() || i >= exp_q.size()) return i;
         if (sent_q[i] !== exp_q[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic [8:0] sent_at(input int i);
      return (i >= 0 && i < sent_q.size()) ? sent_q[i] : 9'h1FF;
   endfunction

   function automatic logic [8:0] exp_at(input int i);
      return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 9'h1FF;
   endfunction

   task automatic wait_ready(output int n);
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic send_char(input logic [7:0] c, output bit ok);
      ok = 1'b0;
      @(negedge clk);
      char_valid = 1'b1;
      char_data  = c;
      for (int n = 0; n < 3000 && !ok; n++) begin
         #1;
         if (char_ready === 1'b1) begin
            @(posedge clk);
            ok = 1'b1;
         end
         @(negedge clk);
      end
      char_valid = 1'b0;
   endtask

   task automatic test_reset();
      int n, hi, d;
      @(negedge clk);
      reset = 1'b0; char_valid = 1'b0; clear_req = 1'b0; char_data = 8'h00;
      repeat (3) @(negedge clk);
      sent_q.delete(); exp_q.delete(); mcol = 0; mrow = 1'b0;
      checks++;
      if ({do_init, do_send_data, data_to_send, lcdrs_in, char_ready, busy, cursor_col, cursor_row}
          !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'h0, 1'b0}) begin
         failures++;
         $display("FAIL reset_values: got init=%b send=%b data=%h rs=%b rdy=%b busy=%b col=%0d row=%b required 0 0 00 0 0 1 0 0",
                  do_init, do_send_data, data_to_send, lcdrs_in, char_ready, busy, cursor_col, cursor_row);
      end
      reset = 1'b1;
      n = 0;
      while (!do_init && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 10) begin
         failures++;
         $display("FAIL pwrup_delay: got %0d cycles required 10", n);
      end
      hi = 0;
      while (do_init && hi < 1000) begin
         @(negedge clk);
         hi++;
      end
      checks++;
      if (hi != INIT_LAT) begin
         failures++;
         $display("FAIL do_init_width: got %0d cycles required %0d", hi, INIT_LAT);
      end
      exp_q.push_back(9'h028); exp_q.push_back(9'h006);
      exp_q.push_back(9'h00C); exp_q.push_back(9'h001);
      wait_ready(n);
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL init_timeout: got busy=%b required 0", busy);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL init_bytes: got %0d bytes required %0d, idx %0d got %h required %h",
                  sent_q.size(), exp_q.size(), d, sent_at(d), exp_at(d));
      end
      checks++;
      if ({char_ready, do_init, cursor_row, cursor_col} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         failures++;
         $display("FAIL ready_after_init: got rdy=%b init=%b row=%b col=%0d required 1 0 0 0",
                  char_ready, do_init, cursor_row, cursor_col);
      end
   endtask

   task automatic test_char();
      bit ok; int n, d;
      send_char(8'h41, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL accept_41: got not accepted required accepted"); end
      checks++;
      if ({do_send_data, lcdrs_in, data_to_send, char_ready} !== {1'b1, 1'b1, 8'h41, 1'b0}) begin
         failures++;
         $display("FAIL latency_41: got send=%b rs=%b data=%h rdy=%b required 1 1 41 0",
                  do_send_data, lcdrs_in, data_to_send, char_ready);
      end
      model_char(8'h41);
      wait_ready(n);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL char_timeout: got busy=%b required 0", busy); end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL char_bytes: got %0d bytes required %0d, idx %0d got %h required %h",
                  sent_q.size(), exp_q.size(), d, sent_at(d), exp_at(d));
      end
      checks++;
      if ({cursor_row, cursor_col} !== {mrow, 4'(mcol)}) begin
         failures++;
         $display("FAIL char_cursor: got (%b,%0d) required (%b,%0d)", cursor_row, cursor_col, mrow, mcol);
      end
   endtask

   task automatic test_clear_collision();
      bit ok; int n, d;
      @(negedge clk);
      clear_req = 1'b1; char_valid = 1'b1; char_data = 8'h42;
      #1;
      checks++;
      if (char_ready !== 1'b0) begin
         failures++;
         $display("FAIL clear_blocks_ready: got %b required 0", char_ready);
      end
      @(negedge clk);
      checks++;
      if ({do_send_data, lcdrs_in, data_to_send} !== {1'b1, 1'b0, 8'h01}) begin
         failures++;
         $display("FAIL clear_wins: got send=%b rs=%b data=%h required 1 0 01",
                  do_send_data, lcdrs_in, data_to_send);
      end
      clear_req = 1'b0; char_valid = 1'b0;
      model_clear();
      wait_ready(n);
      d = first_diff();
      checks++;
      if (d != -1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL clear_bytes: got %0d bytes busy=%b required %0d bytes busy=0, idx %0d got %h required %h",
                  sent_q.size(), busy, exp_q.size(), d, sent_at(d), exp_at(d));
      end
      checks++;
      if ({cursor_row, cursor_col} !== 5'h00) begin
         failures++;
         $display("FAIL clear_cursor: got (%b,%0d) required (0,0)", cursor_row, cursor_col);
      end
      send_char(8'h42, ok);
      model_char(8'h42);
      wait_ready(n);
      d = first_diff();
      checks++;
      if (!ok || d != -1) begin
         failures++;
         $display("FAIL represent_42: got ok=%b %0d bytes required ok=1 %0d bytes, idx %0d got %h required %h",
                  ok, sent_q.size(), exp_q.size(), d, sent_at(d), exp_at(d));
      end
   endtask

   task automatic test_wrap();
      bit ok; int n, d, acc;
      @(negedge clk);
      clear_req = 1'b1;
      @(negedge clk);
      clear_req = 1'b0;
      model_clear();
      wait_ready(n);
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         send_char(8'h61 + 8'(i), ok);
         if (ok) acc++;
         model_char(8'h61 + 8'(i));
      end
      wait_ready(n);
      checks++;
      if (acc != 16 || busy !== 1'b0) begin
         failures++;
         $display("FAIL wrap_accept: got %0d accepted busy=%b required 16 busy=0", acc, busy);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL wrap_bytes: got %0d bytes required %0d, idx %0d got %h required %h",
                  sent_q.size(), exp_q.size(), d, sent_at(d), exp_at(d));
      end
      checks++;
`ifdef LCD_CTRL_LINE_WRAP_EN
      if (sent_at(sent_q.size() - 1) !== 9'h0C0) begin
         failures++;
         $display("FAIL wrap_addr: got last %h required 0c0", sent_at(sent_q.size() - 1));
      end
`else
      if (sent_at(sent_q.size() - 1) !== 9'h170) begin
         failures++;
         $display("FAIL wrap_no_addr: got last %h required 170", sent_at(sent_q.size() - 1));
      end
`endif
      checks++;
      if ({cursor_row, cursor_col} !== {1'b1, 4'h0}) begin
         failures++;
         $display("FAIL wrap_cursor: got (%b,%0d) required (1,0)", cursor_row, cursor_col);
      end
   endtask

   task automatic test_random();
      bit ok; int n, d, acc;
      logic [7:0] c;
      acc = 0;
      for (int i = 0; i < 40; i++) begin
         c = 8'($urandom_range(8'h7E, 8'h20));
         send_char(c, ok);
         if (ok) acc++;
         checks++;
         if ({do_send_data, lcdrs_in, data_to_send} !== {1'b1, 1'b1, c}) begin
            failures++;
            $display("FAIL rand_latency: got send=%b rs=%b data=%h required 1 1 %h",
                     do_send_data, lcdrs_in, data_to_send, c);
         end
         model_char(c);
         if ($urandom_range(5, 0) == 0) begin
            clear_req = 1'b1;
            @(negedge clk);
            clear_req = 1'b0;
            model_clear();
         end
         repeat ($urandom_range(6, 0)) @(negedge clk);
      end
      wait_ready(n);
      checks++;
      if (acc != 40 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rand_accept: got %0d accepted busy=%b required 40 busy=0", acc, busy);
      end
      d = first_diff();
      checks++;
      if (d != -1) begin
         failures++;
         $display("FAIL rand_bytes: got %0d bytes required %0d, idx %0d got %h required %h",
                  sent_q.size(), exp_q.size(), d, sent_at(d), exp_at(d));
      end
      checks++;
      if ({cursor_row, cursor_col} !== {mrow, 4'(mcol)}) begin
         failures++;
         $display("FAIL rand_cursor: got (%b,%0d) required (%b,%0d)", cursor_row, cursor_col, mrow, mcol);
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      send_char(8'h55, ok);
      @(negedge clk);
      checks++;
      if (!ok || do_send_data !== 1'b1) begin
         failures++;
         $display("FAIL mid_setup: got ok=%b send=%b required 1 1", ok, do_send_data);
      end
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({do_send_data, do_init, busy, data_to_send, lcdrs_in, cursor_row, cursor_col}
          !== {1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 4'h0}) begin
         failures++;
         $display("FAIL mid_abort: got send=%b init=%b busy=%b data=%h rs=%b row=%b col=%0d required 0 0 1 00 0 0 0",
                  do_send_data, do_init, busy, data_to_send, lcdrs_in, cursor_row, cursor_col);
      end
      test_reset();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_char();
      test_clear_collision();
      test_wrap();
      test_random();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
